// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Shares one single-port data memory between the core load/store port (c_*)
//   and the debug/loader port (d_*). Each access runs IDLE -> ACCESS -> RESP:
//   it is arbitrated and checked in IDLE, drives one memory cycle in ACCESS,
//   and returns formatted load data plus an error flag in RESP.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   c_req_i/d_req_i           request, held until the matching gnt
//   c_we_i/d_we_i             1 = store, 0 = load
//   c_addr_i/d_addr_i         byte address
//   c_wdata_i/d_wdata_i       right-aligned store data
//   c_size_i/d_size_i         00 byte, 01 half, 10 word, 11 illegal
//   c_unsigned_i/d_unsigned_i zero-extend (1) / sign-extend (0) loads
//   c_gnt_o/d_gnt_o           request accepted this cycle
//   c_rvalid_o/d_rvalid_o     one-cycle response pulse
//   c_rdata_o/d_rdata_o       formatted load data (0 for stores and errors)
//   c_err_o/d_err_o           misaligned / illegal size / out of range
//   mem_*                     memory-side controls; mem_rdata_i is combinational
//   busy_o                    FSM not idle
module dmem_access_ctrl #(
    parameter int DEPTH_WORDS = 8,
    parameter bit RR_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req_i,
    input  logic        c_we_i,
    input  logic [31:0] c_addr_i,
    input  logic [31:0] c_wdata_i,
    input  logic [1:0]  c_size_i,
    input  logic        c_unsigned_i,
    output logic        c_gnt_o,
    output logic        c_rvalid_o,
    output logic [31:0] c_rdata_o,
    output logic        c_err_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [1:0]  d_size_i,
    input  logic        d_unsigned_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,
    output logic        mem_we_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    localparam logic [1:0]  S_IDLE     = 2'd0;
    localparam logic [1:0]  S_ACCESS   = 2'd1;
    localparam logic [1:0]  S_RESP     = 2'd2;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    logic [1:0]  r_state;
    logic        r_favor_d;   // 1: debug wins the next tie (round-robin only)
    logic        r_port;      // 0 core, 1 debug
    logic        r_we;
    logic        r_uns;
    logic        r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_idle;
    logic        w_sel_d;
    logic        w_gnt;
    logic        w_we;
    logic        w_uns;
    logic [1:0]  w_size;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_err;
    logic        w_access_ok;
    logic        w_resp;
    logic [31:0] w_shift;
    logic [31:0] w_fmt;
    logic [31:0] w_rdata;

    // Gating with rst keeps every output low while reset is held.
    assign w_idle  = (r_state == S_IDLE) && !rst;
    assign w_sel_d = d_req_i && (!c_req_i || (RR_EN && r_favor_d));
    assign c_gnt_o = w_idle && c_req_i && !w_sel_d;
    assign d_gnt_o = w_idle && w_sel_d;
    assign w_gnt   = c_gnt_o || d_gnt_o;

    assign w_we    = w_sel_d ? d_we_i       : c_we_i;
    assign w_uns   = w_sel_d ? d_unsigned_i : c_unsigned_i;
    assign w_size  = w_sel_d ? d_size_i     : c_size_i;
    assign w_addr  = w_sel_d ? d_addr_i     : c_addr_i;
    assign w_wdata = w_sel_d ? d_wdata_i    : c_wdata_i;

    assign w_err = (w_size == 2'b11)
                 || ((w_size == 2'b01) && w_addr[0])
                 || ((w_size == 2'b10) && (w_addr[1:0] != 2'b00))
                 || (w_addr >= ADDR_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_favor_d <= 1'b0;
            r_port    <= 1'b0;
            r_we      <= 1'b0;
            r_uns     <= 1'b0;
            r_err     <= 1'b0;
            r_size    <= 2'b00;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_rdata   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt) begin
                        r_state   <= S_ACCESS;
                        r_port    <= w_sel_d;
                        r_favor_d <= !w_sel_d;
                        r_we      <= w_we;
                        r_uns     <= w_uns;
                        r_size    <= w_size;
                        r_addr    <= w_addr;
                        r_wdata   <= w_wdata;
                        r_err     <= w_err;
                    end
                end
                S_ACCESS: begin
                    if (!r_we) r_rdata <= mem_rdata_i;
                    r_state <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory side: only a non-erroring access in ACCESS touches the memory.
    assign w_access_ok = (r_state == S_ACCESS) && !r_err;
    assign mem_we_o    = w_access_ok && r_we;
    assign mem_rd_o    = w_access_ok && !r_we;
    assign mem_addr_o  = w_access_ok ? {r_addr[31:2], 2'b00} : 32'd0;

    always_comb begin
        mem_be_o    = 4'b0000;
        mem_wdata_o = 32'd0;
        if (w_access_ok && r_we) begin
            case (r_size)
                2'b00: begin
                    mem_be_o    = 4'b0001 << r_addr[1:0];
                    mem_wdata_o = {4{r_wdata[7:0]}};
                end
                2'b01: begin
                    mem_be_o    = 4'b0011 << r_addr[1:0];
                    mem_wdata_o = {2{r_wdata[15:0]}};
                end
                default: begin
                    mem_be_o    = 4'b1111;
                    mem_wdata_o = r_wdata;
                end
            endcase
        end
    end

    // Response: bring the addressed lane down to bit 0, then extend.
    assign w_shift = r_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_size)
            2'b00:   w_fmt = r_uns ? {24'd0, w_shift[7:0]}
                                   : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_fmt = r_uns ? {16'd0, w_shift[15:0]}
                                   : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_fmt = w_shift;
        endcase
    end

    assign w_resp     = (r_state == S_RESP);
    assign w_rdata    = (w_resp && !r_we && !r_err) ? w_fmt : 32'd0;
    assign c_rvalid_o = w_resp && !r_port;
    assign d_rvalid_o = w_resp && r_port;
    assign c_err_o    = w_resp && !r_port && r_err;
    assign d_err_o    = w_resp && r_port && r_err;
    assign c_rdata_o  = r_port ? 32'd0 : w_rdata;
    assign d_rdata_o  = r_port ? w_rdata : 32'd0;
    assign busy_o     = (r_state != S_IDLE);

endmodule
